// File: rtl/pwm_capture.sv
// PWM duty-cycle decoder: measures high ticks per period between rising edges, reports steady levels on timeout.
// Optional majority-of-three glitch filter on the enable-sampled input: PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
  parameter int PERIOD  = 256,
  parameter int TIMEOUT = 512
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       pwm_in,
  output logic [7:0] value,
  output logic       valid,
  output logic       period_err
);

  localparam logic [9:0] PERIOD_C  = 10'(PERIOD);
  localparam logic [9:0] TMO_LAST  = 10'(TIMEOUT - 1);

  function automatic logic [7:0] sat8(input logic [9:0] x);
    return (x > 10'd255) ? 8'd255 : x[7:0];
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic       sync1_q, sync2_q, pwm_s;
  logic       sample, rise, tmo;
  logic       last_q, last_d;
  logic [9:0] per_cnt_q, per_cnt_d;
  logic [9:0] high_cnt_q, high_cnt_d;
  logic       armed_q, armed_d;
  logic [7:0] value_q, value_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;

  // Two-flop synchronizer runs every clk, independent of enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
    end
  end

  assign pwm_s = sync2_q;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic [1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (enable) hist_d = {hist_q[0], pwm_s};
  end

  always_ff @(posedge clk) begin
    if (rst) hist_q <= 2'b00;
    else     hist_q <= hist_d;
  end

  assign sample = maj3(pwm_s, hist_q[0], hist_q[1]);
`else
  assign sample = pwm_s;
`endif

  assign rise = enable & sample & ~last_q;
  assign tmo  = enable & ~rise & (per_cnt_q == TMO_LAST);

  always_comb begin
    last_d     = last_q;
    per_cnt_d  = per_cnt_q;
    high_cnt_d = high_cnt_q;
    armed_d    = armed_q;
    value_d    = value_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    if (enable) begin
      last_d = sample;
      if (rise) begin
        if (armed_q) begin
          value_d = sat8(high_cnt_q);
          err_d   = (per_cnt_q != PERIOD_C);
          valid_d = 1'b1;
        end
        // The edge tick itself is the first high tick of the new period.
        per_cnt_d  = 10'd1;
        high_cnt_d = 10'd1;
        armed_d    = 1'b1;
      end else if (tmo) begin
        value_d    = sample ? 8'd255 : 8'd0;
        err_d      = 1'b0;
        valid_d    = 1'b1;
        per_cnt_d  = 10'd0;
        high_cnt_d = 10'd0;
        armed_d    = 1'b0;
      end else begin
        per_cnt_d  = per_cnt_q + 10'd1;
        high_cnt_d = high_cnt_q + {9'd0, sample};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q     <= 1'b0;
      per_cnt_q  <= 10'd0;
      high_cnt_q <= 10'd0;
      armed_q    <= 1'b0;
      value_q    <= 8'd0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      last_q     <= last_d;
      per_cnt_q  <= per_cnt_d;
      high_cnt_q <= high_cnt_d;
      armed_q    <= armed_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign value      = value_q;
  assign valid      = valid_q;
  assign period_err = err_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected results queued as PWM stimulus is driven, compared on each valid.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       pwm_in = 1'b0;
  logic [7:0] value;
  logic       valid;
  logic       period_err;

  always #5 clk = ~clk;

  pwm_capture #(.PERIOD(256), .TIMEOUT(512)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .value      (value),
    .valid      (valid),
    .period_err (period_err)
  );

  typedef struct packed {
    logic [7:0] v;
    logic       e;
  } exp_t;

  exp_t   exp_q[$];
  longint stamps[$];
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;
  int     en_div = 1;
  exp_t   mon_e;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid cycle must match the oldest queued expectation.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      stamps.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got valid with value=%0d period_err=%0b, required no valid", value, period_err);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (value !== mon_e.v) begin
          errors++;
          $display("FAIL value: got %0d, required %0d", value, mon_e.v);
        end
        checks++;
        if (period_err !== mon_e.e) begin
          errors++;
          $display("FAIL period_err: got %0b, required %0b", period_err, mon_e.e);
        end
      end
    end
  end

  task automatic push_exp(input logic [7:0] v, input logic e);
    exp_t x;
    x.v = v;
    x.e = e;
    exp_q.push_back(x);
  endtask

  task automatic tick(input logic lvl);
    pwm_in = lvl;
    enable = 1'b1;
    @(negedge clk);
    if (en_div > 1) begin
      enable = 1'b0;
      repeat (en_div - 1) @(negedge clk);
    end
  endtask

  task automatic drive_range(input int high, input int glitch, input int t0, input int t1);
    for (int t = t0; t < t1; t++) begin
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
      if (glitch >= 0 && t == glitch + 1) push_exp(8'(glitch), 1'b1);
`endif
      tick((t < high) && (t != glitch));
    end
  endtask

  task automatic drive_period(input int high, input int per, input int glitch);
    drive_range(high, glitch, 0, per);
  endtask

  task automatic do_reset();
    pwm_in = 1'b0;
    enable = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    stamps.delete();
  endtask

  task automatic drain_check(input string name);
    repeat (8) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_valid: %0d expected results still pending, required 0", name, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic check_intervals(input string name, input int n, input longint gap);
    checks++;
    if (stamps.size() != n) begin
      errors++;
      $display("FAIL %s_count: got %0d valid pulses, required %0d", name, stamps.size(), n);
    end else begin
      for (int i = 1; i < n; i++) begin
        checks++;
        if (stamps[i] - stamps[i-1] != gap) begin
          errors++;
          $display("FAIL %s_interval: got %0d cycles, required %0d", name, stamps[i] - stamps[i-1], gap);
        end
      end
    end
  endtask

  task automatic test_reset();
    pwm_in = 1'b1;
    enable = 1'b1;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (value !== 8'd0) begin errors++; $display("FAIL reset_value: got %0d, required 0", value); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b, required 0", valid); end
    checks++;
    if (period_err !== 1'b0) begin errors++; $display("FAIL reset_period_err: got %0b, required 0", period_err); end
    rst = 1'b0;
    pwm_in = 1'b0;
  endtask

  task automatic test_duty(input string name, input int high, input int per, input int nper,
                           input logic [7:0] ev, input logic ee);
    do_reset();
    for (int p = 0; p < nper; p++) begin
      if (p > 0) push_exp(ev, ee);
      drive_period(high, per, -1);
    end
    drain_check(name);
    check_intervals(name, nper - 1, longint'(per * en_div));
  endtask

  task automatic test_steady(input string name, input logic lvl);
    do_reset();
    pwm_in = lvl;
    for (int i = 0; i < 3; i++) push_exp(lvl ? 8'd255 : 8'd0, 1'b0);
    for (int i = 0; i < 1560; i++) tick(lvl);
    drain_check(name);
    check_intervals(name, 3, 64'd512);
  endtask

  task automatic test_glitch();
    do_reset();
    for (int p = 0; p < 3; p++) begin
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
      if (p > 0) push_exp(8'd64, 1'b0);
`else
      if (p > 0) push_exp(8'd33, 1'b1);
`endif
      drive_period(64, 256, 30);
    end
    drain_check("glitch");
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_period(64, 256, -1);
    push_exp(8'd64, 1'b0);
    drive_range(64, -1, 0, 100);
    checks++;
    if (value !== 8'd64 || valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_before_reset: got value=%0d valid=%0b, required value=64 valid=0", value, valid);
    end
    rst = 1'b1;
    tick(1'b0);
    checks++;
    if (value !== 8'd0) begin errors++; $display("FAIL midreset_value: got %0d, required 0", value); end
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %0b, required 0", valid); end
    rst = 1'b0;
    drive_range(64, -1, 101, 256);
    drive_period(64, 256, -1);
    push_exp(8'd64, 1'b0);
    drive_period(64, 256, -1);
    drain_check("reset_mid");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_duty("duty64", 64, 256, 4, 8'd64, 1'b0);
`ifndef PWM_CAPTURE_GLITCH_FILTER_EN
    test_duty("duty255", 255, 256, 3, 8'd255, 1'b0);
    test_duty("duty1", 1, 256, 3, 8'd1, 1'b0);
`endif
    test_duty("per200", 50, 200, 3, 8'd50, 1'b1);
    test_duty("saturate", 280, 300, 3, 8'd255, 1'b1);
    test_steady("steady_low", 1'b0);
    test_steady("steady_high", 1'b1);
    test_reset_mid();
    test_glitch();
    en_div = 2;
    test_duty("gated_enable", 64, 256, 3, 8'd64, 1'b0);
    en_div = 1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
